// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types and the stall-unit state encoding.
package lc3b_types;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } lc3b_stall_state;

    localparam lc3b_word PERF_MAX = 16'hFFFF;

endpackage

// File: rtl/resp_hold_buf.sv
// One-word holding register for a cache response that arrived while the pipeline was frozen.
module resp_hold_buf
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     capture,
    input  logic     drop,
    input  lc3b_word word,
    output lc3b_word held,
    output logic     valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            held  <= '0;
            valid <= 1'b0;
        end else if (capture) begin
            held  <= word;
            valid <= 1'b1;
        end else if (drop) begin
            held  <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_stall_unit.sv
// Stall/bubble/flush control for load-use, cache-miss and taken-branch hazards.
// Optional build macro STALL_PERF_EN adds saturating hazard counters and their ports.
module pipeline_stall_unit
    import lc3b_types::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  lc3b_reg         src1_id,
    input  lc3b_reg         src2_id,
    input  logic            src1_used_id,
    input  logic            src2_used_id,
    input  lc3b_reg         dest_ex,
    input  logic            load_regfile_ex,
    input  logic            mem_read_ex,
    input  logic            imem_read,
    input  logic            imem_resp,
    input  lc3b_word        imem_rdata,
    input  logic            dmem_req,
    input  logic            dmem_resp,
    input  lc3b_word        dmem_rdata,
    input  logic            branch_taken_mem,
    output logic            load_pc,
    output logic            load_if_id,
    output logic            load_id_ex,
    output logic            load_ex_mem,
    output logic            load_mem_wb,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            flush_ex_mem,
    output lc3b_word        instr_out,
    output lc3b_word        mem_rdata_out,
    output lc3b_stall_state state
`ifdef STALL_PERF_EN
    ,
    output logic [15:0]     cnt_lu,
    output logic [15:0]     cnt_imiss,
    output logic [15:0]     cnt_dmiss
`endif
);

    lc3b_stall_state state_next;

    logic     ibuf_valid, dbuf_valid;
    lc3b_word ibuf, dbuf;
    logic     lu, ibusy, dbusy, freeze;
    logic     icapture, dcapture;

    // Index 0 = IF/ID ... NUM_STAGES-1 = MEM/WB.
    logic [NUM_STAGES-1:0] stage_load;
    logic [2:0]            stage_flush;
    logic                  pc_load;

    // R0 is a real register here, so no zero-register exemption.
    assign lu = mem_read_ex & load_regfile_ex &
                ((src1_used_id & (dest_ex == src1_id)) |
                 (src2_used_id & (dest_ex == src2_id)));

    // A buffered response counts as completion for that cache.
    assign ibusy  = imem_read & ~imem_resp & ~ibuf_valid;
    assign dbusy  = dmem_req  & ~dmem_resp & ~dbuf_valid;
    assign freeze = ibusy | dbusy;

    always_comb begin
        pc_load     = 1'b1;
        stage_load  = '1;
        stage_flush = '0;
        if (reset) begin
            pc_load = 1'b1;
        end else if (freeze) begin
            pc_load    = 1'b0;
            stage_load = '0;
        end else if (branch_taken_mem) begin
            stage_flush = '1;
        end else if (lu) begin
            pc_load        = 1'b0;
            stage_load[0]  = 1'b0;
            stage_flush[1] = 1'b1;
        end
    end

    assign load_pc      = pc_load;
    assign load_if_id   = stage_load[0];
    assign load_id_ex   = stage_load[1];
    assign load_ex_mem  = stage_load[2];
    assign load_mem_wb  = stage_load[NUM_STAGES-1];
    assign flush_if_id  = stage_flush[0];
    assign flush_id_ex  = stage_flush[1];
    assign flush_ex_mem = stage_flush[2];

    always_comb begin
        state_next = RUN;
        if (!reset && freeze) state_next = WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Only the cache that is not holding things up can be captured during a freeze.
    assign icapture = ~reset & freeze & imem_read & imem_resp & ~ibuf_valid;
    assign dcapture = ~reset & freeze & dmem_req  & dmem_resp & ~dbuf_valid;

    resp_hold_buf u_ibuf (
        .clk     (clk),
        .reset   (reset),
        .capture (icapture),
        .drop    (stage_load[0]),
        .word    (imem_rdata),
        .held    (ibuf),
        .valid   (ibuf_valid)
    );

    resp_hold_buf u_dbuf (
        .clk     (clk),
        .reset   (reset),
        .capture (dcapture),
        .drop    (stage_load[NUM_STAGES-1]),
        .word    (dmem_rdata),
        .held    (dbuf),
        .valid   (dbuf_valid)
    );

    assign instr_out     = ibuf_valid ? ibuf : imem_rdata;
    assign mem_rdata_out = dbuf_valid ? dbuf : dmem_rdata;

`ifdef STALL_PERF_EN
    logic lu_bubble;
    assign lu_bubble = ~freeze & ~branch_taken_mem & lu;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lu    <= '0;
            cnt_imiss <= '0;
            cnt_dmiss <= '0;
        end else begin
            if (lu_bubble && cnt_lu != PERF_MAX) cnt_lu    <= cnt_lu + 16'd1;
            if (ibusy && cnt_imiss != PERF_MAX)  cnt_imiss <= cnt_imiss + 16'd1;
            if (dbusy && cnt_dmiss != PERF_MAX)  cnt_dmiss <= cnt_dmiss + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pipeline_stall_unit.md
Name: pipeline_stall_unit

Overview:
- Counterpart to the operand-forwarding path: resolves the hazards forwarding cannot cover, by stalling, inserting bubbles and flushing.
- Covers load-use, I-cache miss, D-cache miss and taken-branch hazards.
- Drives the load enables of PC and all four pipeline registers, plus per-stage flush (bubble) controls.
- Buffers a cache response that arrives while the pipeline is frozen for the other cache, so the response is not lost.

Parameters:
- NUM_STAGES, 4, number of pipeline registers controlled (IF/ID, ID/EX, EX/MEM, MEM/WB); fixed at 4 and kept only for documentation and assertions.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- src1_id  in  3 (lc3b_reg)  ID-stage source register 1
- src2_id  in  3 (lc3b_reg)  ID-stage source register 2
- src1_used_id  in  1  ID instruction reads src1
- src2_used_id  in  1  ID instruction reads src2
- dest_ex  in  3 (lc3b_reg)  EX-stage destination register
- load_regfile_ex  in  1  EX instruction writes the regfile
- mem_read_ex  in  1  EX instruction is a load (LDR/LDB/LDI)
- imem_read  in  1  I-cache request active
- imem_resp  in  1  I-cache response
- imem_rdata  in  16 (lc3b_word)  I-cache data
- dmem_req  in  1  D-cache read or write active in MEM
- dmem_resp  in  1  D-cache response
- dmem_rdata  in  16 (lc3b_word)  D-cache data
- branch_taken_mem  in  1  taken branch/jump resolved in MEM
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register enables
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load a NOP into the register
- instr_out  out  16  instruction word to IF/ID (live or buffered)
- mem_rdata_out  out  16  data word to MEM/WB (live or buffered)

Behaviour:
- Reset: state=RUN; both buffers invalid and zeroed.
  - All load_* outputs = 1 and all flush_* outputs = 0 while reset is high.
- Hazard flags:
  - lu = mem_read_ex & load_regfile_ex & ((src1_used_id & dest_ex==src1_id) | (src2_used_id & dest_ex==src2_id)).
  - All eight registers are checked; R0 is a real register.
- Completion flags:
  - ibusy = imem_read & ~imem_resp & ~ibuf_valid.
  - dbusy = dmem_req & ~dmem_resp & ~dbuf_valid.
- States:
  - RUN: no freeze.
  - WAIT: at least one cache is busy.
- Per-cycle priority:
  1. reset.
  2. Freeze when ibusy | dbusy. All load_* = 0, no flushes. When the non-busy cache responds this cycle, latch its data into ibuf/dbuf and set that buffer's valid.
  3. Branch flush when branch_taken_mem. All loads = 1; flush_if_id, flush_id_ex and flush_ex_mem = 1.
  4. Load-use when lu. load_pc = load_if_id = 0; flush_id_ex = 1; load_ex_mem and load_mem_wb = 1. This is exactly one bubble; the next cycle has lu=0 because the load has moved to MEM.
  5. Otherwise everything advances.
- Output muxes: instr_out = ibuf_valid ? ibuf : imem_rdata; mem_rdata_out = dbuf_valid ? dbuf : dmem_rdata.
- Buffer release: each valid flag clears on the first cycle in which the pipeline advances (load_if_id=1 for ibuf, load_mem_wb=1 for dbuf).
- Transitions:
  - RUN→WAIT when ibusy | dbusy.
  - WAIT→RUN in the cycle both are clear. That cycle applies priorities 3-5 normally.
- Simultaneous responses: both caches responding in one cycle → no buffering; the pipeline advances immediately.
- Branch with I-cache busy: freeze first; the flush is applied in the cycle imem_resp arrives.
- Reset mid-WAIT: state returns to RUN and buffers clear on the next edge.

Optional Feature: STALL_PERF_EN
- Defined:
  - Adds three 16-bit saturating counters: cnt_lu (load-use bubbles), cnt_imiss (freeze cycles with ibusy), cnt_dmiss (freeze cycles with dbusy).
  - A cycle with both ibusy and dbusy increments both miss counters.
  - Adds output ports of the same names; counters clear on reset.
- Undefined: neither the counters nor the ports exist; all other behaviour is identical.

Decomposition:
- lc3b_types holds lc3b_reg, lc3b_word and a new enum lc3b_stall_state {RUN, WAIT}.
- One sub-module, resp_hold_buf: a 16-bit word plus valid flag with capture and release inputs. Instantiated twice (ibuf, dbuf).

Test Plan:
- LDR R2 in EX, ADD src1=R2 in ID, src1_used=1 → exactly one cycle with load_pc=0, load_if_id=0, flush_id_ex=1; then all loads=1.
- Same as above but src1_used_id=0 → no bubble.
- dmem_req held 5 cycles, dmem_resp in cycle 5 → all loads=0 for cycles 1-4; cycle 5 advances; mem_rdata_out = dmem_rdata.
- imem_read pending; dmem_resp=1 with dmem_rdata=0xBEEF at cycle 2; imem_resp at cycle 6 → freeze through cycle 5; cycle 6 advances with mem_rdata_out=0xBEEF; dbuf invalid by cycle 7.
- branch_taken_mem=1 while ibusy → freeze until imem_resp; in that cycle flush_if_id, flush_id_ex and flush_ex_mem = 1 and load_pc=1.
- reset asserted during WAIT with ibuf valid → next cycle: RUN, all loads=1, instr_out=imem_rdata.
